// File: rtl/pair_triple_seq_ctrl.sv
`default_nettype none
// pair_triple_seq_ctrl -- collects three debounced die entries, runs the detector
// start/done handshake and holds the verdict for display.  Rev 1.0
module pair_triple_seq_ctrl #(
  parameter int MAX_COUNT   = 10000,
  parameter int DEBOUNCE    = 16,
  parameter int DET_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic [2:0] val_in,
  output logic [2:0] det_a,
  output logic [2:0] det_b,
  output logic [2:0] det_c,
  output logic       det_start,
  input  logic       det_done,
  input  logic       det_pair,
  input  logic       det_triple,
  output logic       res_valid,
  output logic       res_pair,
  output logic       res_triple,
  output logic [1:0] slot_cnt,
  output logic       busy,
  output logic       err
);

  localparam int HW = $clog2(MAX_COUNT + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(DET_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_START, S_WAIT, S_HOLD} state_t;

  state_t          state, state_nxt;
  logic            enter_s1, enter_s2, clear_s1, clear_s2;
  logic            filt, filt_q;
  logic [DW-1:0]   db_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            enter_evt, val_ok;
  logic            capture, latch_done, latch_tmo, clear_all, hold_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_s1 <= 1'b0;
      enter_s2 <= 1'b0;
      clear_s1 <= 1'b0;
      clear_s2 <= 1'b0;
    end else begin
      enter_s1 <= btn_enter;
      enter_s2 <= enter_s1;
      clear_s1 <= btn_clear;
      clear_s2 <= clear_s1;
    end
  end

  // Level filter: the synchronized level must disagree with filt for DEBOUNCE cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt   <= 1'b0;
      filt_q <= 1'b0;
      db_cnt <= '0;
    end else if (ena) begin
      filt_q <= filt;
      if (enter_s2 == filt) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE - 1)) begin
        filt   <= enter_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign enter_evt = filt & ~filt_q;
  assign val_ok    = (val_in != 3'd0) && (val_in != 3'd7);
  assign busy      = (state == S_START) || (state == S_WAIT) || (state == S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    latch_done = 1'b0;
    latch_tmo  = 1'b0;
    clear_all  = 1'b0;
    hold_done  = 1'b0;
    det_start  = 1'b0;
    err        = 1'b0;
    if (ena) begin
      if (clear_s2) begin
        clear_all = 1'b1;
        state_nxt = S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_COLLECT: begin
            if (enter_evt) begin
              if (val_ok) begin
                capture   = 1'b1;
                state_nxt = (slot_cnt == 2'd2) ? S_START : S_COLLECT;
              end else begin
                err = 1'b1;
              end
            end
          end
          S_START: begin
            det_start = 1'b1;
            state_nxt = S_WAIT;
          end
          S_WAIT: begin
            // A done on the expiry cycle wins over the timeout.
            if (det_done) begin
              latch_done = 1'b1;
              state_nxt  = S_HOLD;
            end else if (tmo_cnt == TW'(DET_TIMEOUT - 1)) begin
              latch_tmo = 1'b1;
              err       = 1'b1;
              state_nxt = S_HOLD;
            end
          end
          S_HOLD: begin
            if (hold_cnt == HW'(MAX_COUNT - 1)) begin
              hold_done = 1'b1;
              state_nxt = S_IDLE;
            end
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_a      <= 3'd0;
      det_b      <= 3'd0;
      det_c      <= 3'd0;
      slot_cnt   <= 2'd0;
      res_valid  <= 1'b0;
      res_pair   <= 1'b0;
      res_triple <= 1'b0;
      tmo_cnt    <= '0;
      hold_cnt   <= '0;
    end else if (ena) begin
      if (clear_all || hold_done) begin
        det_a      <= 3'd0;
        det_b      <= 3'd0;
        det_c      <= 3'd0;
        slot_cnt   <= 2'd0;
        res_valid  <= 1'b0;
        res_pair   <= 1'b0;
        res_triple <= 1'b0;
      end else if (capture) begin
        case (slot_cnt)
          2'd0:    det_a <= val_in;
          2'd1:    det_b <= val_in;
          default: det_c <= val_in;
        endcase
        slot_cnt <= slot_cnt + 2'd1;
      end else if (latch_done) begin
        res_valid  <= 1'b1;
        res_triple <= det_triple;
        res_pair   <= det_pair & ~det_triple;
      end else if (latch_tmo) begin
        res_valid  <= 1'b1;
        res_triple <= 1'b0;
        res_pair   <= 1'b0;
      end
      tmo_cnt  <= (state == S_WAIT && state_nxt == S_WAIT) ? tmo_cnt + TW'(1) : '0;
      hold_cnt <= (state == S_HOLD && state_nxt == S_HOLD) ? hold_cnt + HW'(1) : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pair_triple_seq_ctrl.sv
`default_nettype none
// tb_pair_triple_seq_ctrl -- scenario tasks against a verdict/timing model of the sequencer.
module tb_pair_triple_seq_ctrl;

  localparam int MAX_COUNT   = 20;
  localparam int DEBOUNCE    = 4;
  localparam int DET_TIMEOUT = 15;

  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
  logic       btn_enter = 1'b0, btn_clear = 1'b0;
  logic [2:0] val_in = 3'd0;
  logic       det_done = 1'b0, det_pair = 1'b0, det_triple = 1'b0;
  logic [2:0] det_a, det_b, det_c;
  logic       det_start, res_valid, res_pair, res_triple, busy, err;
  logic [1:0] slot_cnt;

  int checks = 0;
  int errors = 0;

  pair_triple_seq_ctrl #(
    .MAX_COUNT(MAX_COUNT), .DEBOUNCE(DEBOUNCE), .DET_TIMEOUT(DET_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .val_in(val_in), .det_a(det_a), .det_b(det_b), .det_c(det_c), .det_start(det_start),
    .det_done(det_done), .det_pair(det_pair), .det_triple(det_triple),
    .res_valid(res_valid), .res_pair(res_pair), .res_triple(res_triple),
    .slot_cnt(slot_cnt), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Reference verdict: triple when all equal; displayed pair only when not a triple.
  function automatic logic any_pair(input logic [2:0] a, b, c);
    return (a == b) || (b == c) || (a == c);
  endfunction
  function automatic logic all_same(input logic [2:0] a, b, c);
    return (a == b) && (b == c);
  endfunction

  // Settle with button released, then hold ENTER; capture is due DEBOUNCE+3 edges later.
  task automatic press(input logic [2:0] v, output logic [1:0] slot_before,
                       output logic [1:0] slot_after, output logic err_at,
                       output logic err_after, output logic start_after);
    btn_enter = 1'b0;
    repeat (DEBOUNCE + 4) @(negedge clk);
    val_in    = v;
    btn_enter = 1'b1;
    repeat (DEBOUNCE + 2) @(negedge clk);
    slot_before = slot_cnt;
    err_at      = err;
    @(negedge clk);
    slot_after  = slot_cnt;
    err_after   = err;
    start_after = det_start;
    btn_enter   = 1'b0;
  endtask

  task automatic load3(input logic [2:0] a, b, c);
    logic [1:0] sb, sa;
    logic ea, ef, st;
    press(a, sb, sa, ea, ef, st);
    press(b, sb, sa, ea, ef, st);
    press(c, sb, sa, ea, ef, st);
  endtask

  task automatic pulse_clear();
    btn_clear = 1'b1;
    @(negedge clk);
    btn_clear = 1'b0;
  endtask

  task automatic test_reset();
    ena   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({det_a, det_b, det_c, det_start, res_valid, res_pair, res_triple, slot_cnt, busy, err} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {det_a, det_b, det_c, det_start, res_valid, res_pair, res_triple, slot_cnt, busy, err});
    end
  endtask

  task automatic test_main(input logic [2:0] a, b, c);
    logic [2:0] v[3];
    logic [1:0] sb, sa;
    logic ea, ef, st, tp, pp;
    int hold_cycles;
    v[0] = a; v[1] = b; v[2] = c;
    tp = all_same(a, b, c);
    pp = any_pair(a, b, c);
    for (int k = 0; k < 3; k++) begin
      press(v[k], sb, sa, ea, ef, st);
      checks++;
      if (sb !== 2'(k) || sa !== 2'(k + 1)) begin
        errors++;
        $display("FAIL capture_slot: got %0d->%0d expected %0d->%0d", sb, sa, k, k + 1);
      end
      checks++;
      if (st !== (k == 2)) begin
        errors++;
        $display("FAIL start_timing: capture %0d det_start=%0b expected %0b", k, st, k == 2);
      end
    end
    checks++;
    if ({det_a, det_b, det_c} !== {a, b, c}) begin
      errors++;
      $display("FAIL det_values: got %0d/%0d/%0d expected %0d/%0d/%0d", det_a, det_b, det_c, a, b, c);
    end
    @(negedge clk);
    checks++;
    if (det_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_width: det_start=%0b busy=%0b expected 0/1", det_start, busy);
    end
    repeat ($urandom_range(0, 8)) @(negedge clk);
    det_done = 1'b1; det_pair = pp; det_triple = tp;
    @(negedge clk);
    det_done = 1'b0; det_pair = 1'b0; det_triple = 1'b0;
    checks++;
    if ({res_valid, res_pair, res_triple} !== {1'b1, pp & ~tp, tp}) begin
      errors++;
      $display("FAIL verdict: got v%0b p%0b t%0b expected v1 p%0b t%0b",
               res_valid, res_pair, res_triple, pp & ~tp, tp);
    end
    hold_cycles = 1;
    for (int i = 0; i < 4 * MAX_COUNT; i++) begin
      @(negedge clk);
      if (!res_valid) break;
      hold_cycles++;
    end
    checks++;
    if (hold_cycles !== MAX_COUNT) begin
      errors++;
      $display("FAIL hold_time: got %0d cycles expected %0d", hold_cycles, MAX_COUNT);
    end
    checks++;
    if ({slot_cnt, det_a, res_pair, res_triple, busy} !== 8'd0) begin
      errors++;
      $display("FAIL rearm: slot=%0d det_a=%0d p=%0b t=%0b busy=%0b expected all 0",
               slot_cnt, det_a, res_pair, res_triple, busy);
    end
  endtask

  task automatic test_invalid();
    logic [2:0] bad[2];
    logic [1:0] sb, sa;
    logic ea, ef, st;
    bad[0] = 3'd0; bad[1] = 3'd7;
    for (int k = 0; k < 2; k++) begin
      press(bad[k], sb, sa, ea, ef, st);
      checks++;
      if (ea !== 1'b1 || ef !== 1'b0 || sa !== 2'd0) begin
        errors++;
        $display("FAIL invalid_value: val %0d err %0b,%0b slot %0d expected 1,0 slot 0", bad[k], ea, ef, sa);
      end
    end
    // glitch shorter than the debounce window
    repeat (DEBOUNCE + 4) @(negedge clk);
    val_in = 3'd2;
    btn_enter = 1'b1;
    repeat (DEBOUNCE - 1) @(negedge clk);
    btn_enter = 1'b0;
    repeat (DEBOUNCE + 6) @(negedge clk);
    checks++;
    if (slot_cnt !== 2'd0 || det_a !== 3'd0) begin
      errors++;
      $display("FAIL glitch: slot=%0d det_a=%0d expected 0/0", slot_cnt, det_a);
    end
  endtask

  task automatic test_timeout();
    int found = 0;
    load3(3'($urandom_range(1, 6)), 3'($urandom_range(1, 6)), 3'($urandom_range(1, 6)));
    for (int m = 1; m <= 3 * DET_TIMEOUT; m++) begin
      @(negedge clk);
      if (err) begin
        found = m;
        break;
      end
    end
    checks++;
    if (found !== DET_TIMEOUT) begin
      errors++;
      $display("FAIL timeout_err: err on wait cycle %0d expected %0d", found, DET_TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if ({res_valid, res_pair, res_triple, err} !== 4'b1000) begin
      errors++;
      $display("FAIL timeout_result: got v%0b p%0b t%0b e%0b expected v1 p0 t0 e0",
               res_valid, res_pair, res_triple, err);
    end
    det_done = 1'b1; det_pair = 1'b1; det_triple = 1'b1;
    @(negedge clk);
    det_done = 1'b0; det_pair = 1'b0; det_triple = 1'b0;
    checks++;
    if ({res_valid, res_pair, res_triple} !== 3'b100) begin
      errors++;
      $display("FAIL late_done_hold: got v%0b p%0b t%0b expected v1 p0 t0", res_valid, res_pair, res_triple);
    end
    for (int i = 0; i < 4 * MAX_COUNT && res_valid; i++) @(negedge clk);
  endtask

  task automatic test_clear();
    logic [1:0] sb, sa;
    logic ea, ef, st;
    press(3'd1, sb, sa, ea, ef, st);
    press(3'd6, sb, sa, ea, ef, st);
    pulse_clear();
    @(negedge clk);
    checks++;
    if (slot_cnt !== 2'd2) begin
      errors++;
      $display("FAIL clear_sync_delay: slot=%0d expected 2", slot_cnt);
    end
    @(negedge clk);
    checks++;
    if ({slot_cnt, det_a, det_b, busy} !== 9'd0) begin
      errors++;
      $display("FAIL clear_collect: slot=%0d a=%0d b=%0d busy=%0b expected 0", slot_cnt, det_a, det_b, busy);
    end
    // clear during HOLD
    load3(3'd2, 3'd2, 3'd5);
    @(negedge clk);
    det_done = 1'b1; det_pair = 1'b1;
    @(negedge clk);
    det_done = 1'b0; det_pair = 1'b0;
    pulse_clear();
    repeat (2) @(negedge clk);
    checks++;
    if ({res_valid, res_pair, busy, slot_cnt, det_a, det_b, det_c} !== 14'd0) begin
      errors++;
      $display("FAIL clear_hold: v=%0b p=%0b busy=%0b slot=%0d expected 0", res_valid, res_pair, busy, slot_cnt);
    end
    // clear reaching the FSM on the same edge as det_done
    load3(3'd4, 3'd1, 3'd4);
    @(negedge clk);
    pulse_clear();
    @(negedge clk);
    det_done = 1'b1; det_pair = 1'b1;
    @(negedge clk);
    det_done = 1'b0; det_pair = 1'b0;
    checks++;
    if ({res_valid, res_pair, busy, slot_cnt} !== 5'd0) begin
      errors++;
      $display("FAIL clear_vs_done: v=%0b p=%0b busy=%0b slot=%0d expected 0", res_valid, res_pair, busy, slot_cnt);
    end
    det_done = 1'b1; det_pair = 1'b1;
    @(negedge clk);
    det_done = 1'b0; det_pair = 1'b0;
    @(negedge clk);
    checks++;
    if ({res_valid, res_pair, busy} !== 3'd0) begin
      errors++;
      $display("FAIL abandoned_done: v=%0b p=%0b busy=%0b expected 0", res_valid, res_pair, busy);
    end
  endtask

  task automatic test_ena();
    int hold_cycles = 1;
    load3(3'd6, 3'd3, 3'd6);
    @(negedge clk);
    det_done = 1'b1; det_pair = 1'b1;
    @(negedge clk);
    det_done = 1'b0; det_pair = 1'b0;
    for (int i = 0; i < 6 * MAX_COUNT; i++) begin
      @(negedge clk);
      if (!res_valid) break;
      hold_cycles++;
      if (hold_cycles == 5)  ena = 1'b0;
      if (hold_cycles == 15) ena = 1'b1;
    end
    ena = 1'b1;
    checks++;
    if (hold_cycles !== MAX_COUNT + 10) begin
      errors++;
      $display("FAIL ena_freeze: hold %0d cycles expected %0d", hold_cycles, MAX_COUNT + 10);
    end
  endtask

  task automatic test_async_reset();
    load3(3'd5, 3'd5, 3'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({det_a, det_b, det_c, det_start, res_valid, busy, slot_cnt, err} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset: a=%0d b=%0d c=%0d busy=%0b slot=%0d expected 0",
               det_a, det_b, det_c, busy, slot_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_main(3'd3, 3'd5, 3'd3);
    test_main(3'd4, 3'd4, 3'd4);
    for (int n = 0; n < 3; n++)
      test_main(3'($urandom_range(1, 6)), 3'($urandom_range(1, 6)), 3'($urandom_range(1, 6)));
    test_invalid();
    test_timeout();
    test_clear();
    test_ena();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pair_triple_seq_ctrl.md
Name: pair_triple_seq_ctrl

Overview:
Front-end sequencer for the pair/triple detector. It collects three die values (1..6), entered one at a time with a debounced ENTER button. It then issues a start/done handshake to the detector, latches the verdict, and holds it for display for MAX_COUNT cycles before re-arming. It sits between the top-level ui_in pins and the detector datapath.

Parameters:
MAX_COUNT, 10000, result hold time in clk cycles (>=1); counter width $clog2(MAX_COUNT+1)
DEBOUNCE, 16, consecutive stable cycles required to accept a button level change (>=1)
DET_TIMEOUT, 15, cycles to wait for det_done before aborting (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  design enable; low freezes FSM and counters
btn_enter  in  1  raw ENTER button (asynchronous)
btn_clear  in  1  raw CLEAR (asynchronous; synchronized, not debounced)
val_in  in  3  die value to capture on ENTER
det_a  out  3  captured value 0 to detector
det_b  out  3  captured value 1 to detector
det_c  out  3  captured value 2 to detector
det_start  out  1  one-cycle request pulse to detector
det_done  in  1  detector response strobe
det_pair  in  1  detector pair flag, valid with det_done
det_triple  in  1  detector triple flag, valid with det_done
res_valid  out  1  result being displayed
res_pair  out  1  latched pair verdict
res_triple  out  1  latched triple verdict
slot_cnt  out  2  values captured so far (0..3)
busy  out  1  high in START/WAIT/HOLD
err  out  1  one-cycle pulse: invalid value or detector timeout

Behaviour:
- Reset (rst_n low, async): all outputs 0, FSM=IDLE, all counters 0, debounce filter level 0.
- Synchronizers: btn_enter and btn_clear each pass through a 2-flop synchronizer. These run regardless of ena.
- Debounce:
  - filt changes to the synchronized level once that level has differed from filt for DEBOUNCE consecutive cycles. Any agreeing cycle resets the count.
  - enter_evt is a 1-cycle pulse the cycle after filt rises.
  - Latency: DEBOUNCE+3 edges from the first edge sampling btn_enter high.
  - Glitches shorter than DEBOUNCE produce no event.
- ena low: FSM, hold/timeout counters, debounce counter and captures are frozen. det_start and err are forced 0. Other outputs hold their values.
- Value validity: 1..6 is valid. 0 and 7 are invalid: enter_evt produces an err pulse and no capture, and slot_cnt is unchanged.
- FSM states: IDLE, COLLECT, START, WAIT, HOLD.
  - IDLE / COLLECT: a valid enter_evt writes val_in to det_a, det_b, det_c in order and increments slot_cnt. The first capture moves the FSM to COLLECT. The third capture (slot_cnt becomes 3) moves it to START.
  - START: det_start=1 for exactly one cycle, then WAIT. busy=1.
  - WAIT: timeout counter increments each cycle.
    - det_done=1: res_triple<=det_triple, res_pair<=det_pair & ~det_triple (triple dominates), res_valid<=1, go to HOLD.
    - No det_done after DET_TIMEOUT cycles in WAIT: res_valid<=1, res_pair=res_triple=0, err pulse, go to HOLD.
    - det_done on the same cycle as the timeout expiry counts as done.
  - HOLD: counts MAX_COUNT cycles. On expiry, in the same transition: res_*<=0, slot_cnt<=0, det_a/b/c<=0, go to IDLE.
- Ignored inputs:
  - enter_evt is ignored in START, WAIT and HOLD (no err).
  - det_done outside WAIT is ignored.
- Synchronized CLEAR high (level, any state):
  - Next state IDLE; slot_cnt, det_a/b/c, res_*, busy and the counters are cleared.
  - Has priority over enter_evt, det_done and HOLD expiry in the same cycle.
  - Clearing in WAIT leaves the detector handshake abandoned; a late det_done is then ignored.
- busy: combinational from state, high in START, WAIT and HOLD.

Test Plan:
- DEBOUNCE=4: enter 3,5,3 → det_a/b/c=3/5/3 and slot_cnt 1,2,3. det_start pulses exactly 1 cycle after the third capture. det_done with pair=1 → res_valid=1, res_pair=1; both return to 0 exactly MAX_COUNT(=20) cycles later, with slot_cnt=0.
- Values 4,4,4, detector returns pair=1 and triple=1 → res_triple=1, res_pair=0.
- val_in=0 and val_in=7 on ENTER → err 1-cycle pulse each, slot_cnt stays 0. A 3-cycle ENTER glitch (DEBOUNCE=4) → no capture.
- det_done never asserted, DET_TIMEOUT=15 → err pulse on the 15th WAIT cycle, res_valid=1 with both flags 0. A det_done arriving later in HOLD is ignored.
- CLEAR in COLLECT (slot_cnt=2) and in HOLD → IDLE next cycle, all outputs 0. CLEAR coincident with det_done → no result latched.
- ena low for 10 cycles mid-HOLD → res_valid extended by exactly 10 cycles. rst_n asserted mid-WAIT → outputs 0 immediately, without waiting for a clock edge.
